// File: rtl/logic_result_checker_pkg.sv
// Shared types and constants for the logic result checker: FSM states,
// error-mask bit positions, counter width and counter update helpers.
package logic_result_checker_pkg;

    // Checker operating state: RUN accepts result sets, HALT refuses them.
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    // Bit positions inside the per-verdict error mask.
    localparam int NAND_BIT = 0;
    localparam int NOR_BIT  = 1;
    localparam int XNOR_BIT = 2;
    localparam int XOR_BIT  = 3;
    localparam int MASK_W   = 4;

    // Verdict and error counters.
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Increment that rolls over from all-ones back to zero.
    function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] value);
        return value + CNT_ONE;
    endfunction

    // Increment that sticks at all-ones instead of rolling over.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

endpackage : logic_result_checker_pkg

// File: rtl/logic_result_checker_if.sv
// Result-set intake and verdict handshake bundle of the logic result checker.
// The master side presents result sets and consumes verdicts; the slave side
// is the checker itself.
interface logic_result_checker_if #(
    parameter int W = 8
);
    import logic_result_checker_pkg::*;

    // Intake handshake and the six results under check.
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      and_in;
    logic [W-1:0]      nand_in;
    logic [W-1:0]      or_in;
    logic [W-1:0]      nor_in;
    logic [W-1:0]      xor_in;
    logic [W-1:0]      xnor_in;

    // Verdict handshake.
    logic              out_valid;
    logic              out_ready;
    logic              out_ok;
    logic [MASK_W-1:0] out_err_mask;

    modport master (
        output in_valid,
        output and_in,
        output nand_in,
        output or_in,
        output nor_in,
        output xor_in,
        output xnor_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_ok,
        input  out_err_mask
    );

    modport slave (
        input  in_valid,
        input  and_in,
        input  nand_in,
        input  or_in,
        input  nor_in,
        input  xor_in,
        input  xnor_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_ok,
        output out_err_mask
    );

endinterface : logic_result_checker_if

// File: rtl/logic_result_checker_check.sv
// Purely combinational consistency check of six W-bit logic results.
// Each mask bit flags one relation that does not hold:
//   NAND_BIT : nand is not the complement of and
//   NOR_BIT  : nor is not the complement of or
//   XNOR_BIT : xnor is not the complement of xor
//   XOR_BIT  : xor differs from (or & ~and), or and has a bit that or lacks
module logic_consistency_check
    import logic_result_checker_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]      and_in,
    input  logic [W-1:0]      nand_in,
    input  logic [W-1:0]      or_in,
    input  logic [W-1:0]      nor_in,
    input  logic [W-1:0]      xor_in,
    input  logic [W-1:0]      xnor_in,
    output logic [MASK_W-1:0] err_mask
);

    logic [W-1:0] xor_ref_s;
    logic [W-1:0] and_excess_s;

    // Reference xor derived from and/or, plus and bits not covered by or.
    always_comb begin
        xor_ref_s    = or_in & ~and_in;
        and_excess_s = and_in & ~or_in;
    end

    // Evaluate each relation into its own mask bit.
    always_comb begin
        err_mask           = {MASK_W{1'b0}};
        err_mask[NAND_BIT] = (nand_in != ~and_in);
        err_mask[NOR_BIT]  = (nor_in != ~or_in);
        err_mask[XNOR_BIT] = (xnor_in != ~xor_in);
        err_mask[XOR_BIT]  = (xor_in != xor_ref_s) || (and_excess_s != {W{1'b0}});
    end

endmodule : logic_consistency_check

// File: rtl/logic_result_checker.sv
// Logic result checker: accepts result sets over a valid/ready handshake,
// registers a verdict one cycle later, and keeps verdict/error statistics.
// With HALT_ON_ERR set, the first failed verdict parks the block in HALT
// until a clear pulse. A pending verdict always drains, even in HALT.
module logic_result_checker
    import logic_result_checker_pkg::*;
#(
    parameter int W           = 8,
    parameter bit HALT_ON_ERR = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    logic_result_checker_if.slave  bus,
    output logic                   err_sticky,
    output logic                   halted,
    output logic [CNT_W-1:0]       check_count,
    output logic [CNT_W-1:0]       err_count
);

    // Combinational check result and handshake qualifiers.
    logic [MASK_W-1:0] mask_s;
    logic              fail_s;
    logic              in_ready_s;
    logic              xfer_s;

    // FSM.
    state_e            state_r;
    state_e            state_next_s;

    // Verdict registers.
    logic              out_valid_r;
    logic              out_valid_next_s;
    logic              out_ok_r;
    logic              out_ok_next_s;
    logic [MASK_W-1:0] err_mask_r;
    logic [MASK_W-1:0] err_mask_next_s;

    // Statistics registers; the *_base_s values are the post-clear view.
    logic              err_sticky_r;
    logic              err_sticky_next_s;
    logic              err_sticky_base_s;
    logic [CNT_W-1:0]  check_count_r;
    logic [CNT_W-1:0]  check_count_next_s;
    logic [CNT_W-1:0]  check_count_base_s;
    logic [CNT_W-1:0]  err_count_r;
    logic [CNT_W-1:0]  err_count_next_s;
    logic [CNT_W-1:0]  err_count_base_s;

    logic_consistency_check #(
        .W (W)
    ) u_check (
        .and_in   (bus.and_in),
        .nand_in  (bus.nand_in),
        .or_in    (bus.or_in),
        .nor_in   (bus.nor_in),
        .xor_in   (bus.xor_in),
        .xnor_in  (bus.xnor_in),
        .err_mask (mask_s)
    );

    // Intake is open in RUN whenever the verdict slot is free or being drained.
    always_comb begin
        fail_s     = (mask_s != {MASK_W{1'b0}});
        in_ready_s = (state_r == RUN) && (!out_valid_r || bus.out_ready);
        xfer_s     = bus.in_valid && in_ready_s;
    end

    // Next state: a failed verdict halts (if enabled); only clear resumes.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RUN: begin
                if (xfer_s && fail_s && (HALT_ON_ERR == 1'b1)) begin
                    state_next_s = HALT;
                end else begin
                    state_next_s = RUN;
                end
            end
            HALT: begin
                if (clear) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = HALT;
                end
            end
            default: begin
                state_next_s = RUN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Verdict slot: load on transfer, release on out_ready, otherwise hold.
    always_comb begin
        out_valid_next_s = out_valid_r;
        out_ok_next_s    = out_ok_r;
        err_mask_next_s  = err_mask_r;
        if (xfer_s) begin
            out_valid_next_s = 1'b1;
            out_ok_next_s    = !fail_s;
            err_mask_next_s  = mask_s;
        end else if (bus.out_ready) begin
            out_valid_next_s = 1'b0;
        end else begin
            out_valid_next_s = out_valid_r;
        end
    end

    // Verdict registers; clear intentionally leaves a pending verdict alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_ok_r    <= 1'b0;
            err_mask_r  <= {MASK_W{1'b0}};
        end else begin
            out_valid_r <= out_valid_next_s;
            out_ok_r    <= out_ok_next_s;
            err_mask_r  <= err_mask_next_s;
        end
    end

    // Statistics update: clear zeroes first, then a same-cycle verdict counts.
    always_comb begin
        check_count_base_s = check_count_r;
        err_count_base_s   = err_count_r;
        err_sticky_base_s  = err_sticky_r;
        if (clear) begin
            check_count_base_s = CNT_ZERO;
            err_count_base_s   = CNT_ZERO;
            err_sticky_base_s  = 1'b0;
        end else begin
            check_count_base_s = check_count_r;
            err_count_base_s   = err_count_r;
            err_sticky_base_s  = err_sticky_r;
        end

        check_count_next_s = check_count_base_s;
        err_count_next_s   = err_count_base_s;
        err_sticky_next_s  = err_sticky_base_s;
        if (xfer_s) begin
            check_count_next_s = wrap_inc(check_count_base_s);
            if (fail_s) begin
                err_count_next_s  = sat_inc(err_count_base_s);
                err_sticky_next_s = 1'b1;
            end else begin
                err_count_next_s  = err_count_base_s;
                err_sticky_next_s = err_sticky_base_s;
            end
        end else begin
            check_count_next_s = check_count_base_s;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            check_count_r <= CNT_ZERO;
            err_count_r   <= CNT_ZERO;
            err_sticky_r  <= 1'b0;
        end else begin
            check_count_r <= check_count_next_s;
            err_count_r   <= err_count_next_s;
            err_sticky_r  <= err_sticky_next_s;
        end
    end

    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_ok       = out_ok_r;
    assign bus.out_err_mask = err_mask_r;
    assign err_sticky       = err_sticky_r;
    assign halted           = (state_r == HALT);
    assign check_count      = check_count_r;
    assign err_count        = err_count_r;

endmodule : logic_result_checker

// File: tb/tb_logic_result_checker.sv
// Directed bench for logic_result_checker: dut0 runs without halting,
// dut1 halts on the first error. Outputs are sampled on the falling edge,
// inputs change on the falling edge.
module tb_logic_result_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear0;
    logic        clear1;
    logic        sticky0;
    logic        sticky1;
    logic        halted0;
    logic        halted1;
    logic [15:0] cc0;
    logic [15:0] cc1;
    logic [15:0] ec0;
    logic [15:0] ec1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_result_checker_if #(.W(8)) if0 ();
    logic_result_checker_if #(.W(8)) if1 ();

    logic_result_checker #(.W(8), .HALT_ON_ERR(1'b0)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear0),
        .bus         (if0.slave),
        .err_sticky  (sticky0),
        .halted      (halted0),
        .check_count (cc0),
        .err_count   (ec0)
    );

    logic_result_checker #(.W(8), .HALT_ON_ERR(1'b1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear1),
        .bus         (if1.slave),
        .err_sticky  (sticky1),
        .halted      (halted1),
        .check_count (cc1),
        .err_count   (ec1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic [7:0] a, na, o, no, x, xn);
        if0.and_in  = a;
        if0.nand_in = na;
        if0.or_in   = o;
        if0.nor_in  = no;
        if0.xor_in  = x;
        if0.xnor_in = xn;
    endtask

    task automatic set1(input logic [7:0] a, na, o, no, x, xn);
        if1.and_in  = a;
        if1.nand_in = na;
        if1.or_in   = o;
        if1.nor_in  = no;
        if1.xor_in  = x;
        if1.xnor_in = xn;
    endtask

    task automatic expect0(input string tag, input logic v, input logic ok, input logic [3:0] m,
                           input logic st, input logic [15:0] c, input logic [15:0] e);
        chk({tag, ".valid"},  32'(if0.out_valid),    32'(v));
        chk({tag, ".ok"},     32'(if0.out_ok),       32'(ok));
        chk({tag, ".mask"},   32'(if0.out_err_mask), 32'(m));
        chk({tag, ".sticky"}, 32'(sticky0),          32'(st));
        chk({tag, ".cnt"},    32'(cc0),              32'(c));
        chk({tag, ".errcnt"}, 32'(ec0),              32'(e));
    endtask

    task automatic expect1(input string tag, input logic v, input logic ok, input logic [3:0] m,
                           input logic st, input logic [15:0] c, input logic [15:0] e,
                           input logic h, input logic rdy);
        chk({tag, ".valid"},  32'(if1.out_valid),    32'(v));
        chk({tag, ".ok"},     32'(if1.out_ok),       32'(ok));
        chk({tag, ".mask"},   32'(if1.out_err_mask), 32'(m));
        chk({tag, ".sticky"}, 32'(sticky1),          32'(st));
        chk({tag, ".cnt"},    32'(cc1),              32'(c));
        chk({tag, ".errcnt"}, 32'(ec1),              32'(e));
        chk({tag, ".halted"}, 32'(halted1),          32'(h));
        chk({tag, ".ready"},  32'(if1.in_ready),     32'(rdy));
    endtask

    initial begin
        rst_n         = 1'b0;
        clear0        = 1'b0;
        clear1        = 1'b0;
        if0.in_valid  = 1'b0;
        if0.out_ready = 1'b1;
        if1.in_valid  = 1'b0;
        if1.out_ready = 1'b1;
        set0(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        set1(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        // Reset values.
        repeat (2) @(negedge clk);
        expect0("rst", 1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 16'h0000);
        chk("rst.halted0", 32'(halted0), 32'h0);
        chk("rst.halted1", 32'(halted1), 32'h0);

        // Basic verdicts, one transfer per cycle starting right after reset.
        rst_n = 1'b1;
        if0.in_valid = 1'b1;
        set0(8'h24, 8'hDB, 8'hBD, 8'h42, 8'h99, 8'h66);
        @(negedge clk);
        expect0("good", 1'b1, 1'b1, 4'h0, 1'b0, 16'd1, 16'd0);
        set0(8'h24, 8'hDA, 8'hBD, 8'h42, 8'h99, 8'h66);
        @(negedge clk);
        expect0("nand", 1'b1, 1'b0, 4'h1, 1'b1, 16'd2, 16'd1);
        set0(8'h25, 8'hDA, 8'hBD, 8'h42, 8'h99, 8'h66);
        @(negedge clk);
        expect0("and25", 1'b1, 1'b0, 4'h8, 1'b1, 16'd3, 16'd2);
        set0(8'h24, 8'hDB, 8'hBD, 8'h43, 8'h99, 8'h66);
        @(negedge clk);
        expect0("nor", 1'b1, 1'b0, 4'h2, 1'b1, 16'd4, 16'd3);
        set0(8'h24, 8'hDB, 8'hBD, 8'h42, 8'h99, 8'h67);
        @(negedge clk);
        expect0("xnor", 1'b1, 1'b0, 4'h4, 1'b1, 16'd5, 16'd4);
        set0(8'h01, 8'hFE, 8'h00, 8'hFF, 8'h00, 8'hFF);
        @(negedge clk);
        expect0("andexcess", 1'b1, 1'b0, 4'h8, 1'b1, 16'd6, 16'd5);
        set0(8'hF0, 8'h0F, 8'hFF, 8'h00, 8'h0F, 8'hF0);
        @(negedge clk);
        expect0("goodF0", 1'b1, 1'b1, 4'h0, 1'b1, 16'd7, 16'd5);

        // Backpressure: verdict held, intake closed, counters frozen.
        if0.out_ready = 1'b0;
        set0(8'h24, 8'hDA, 8'hBD, 8'h42, 8'h99, 8'h66);
        #1;
        chk("bp.ready0", 32'(if0.in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect0("bp.hold", 1'b1, 1'b1, 4'h0, 1'b1, 16'd7, 16'd5);
            chk("bp.ready", 32'(if0.in_ready), 32'h0);
        end
        if0.out_ready = 1'b1;
        #1;
        chk("bp.ready1", 32'(if0.in_ready), 32'h1);
        @(negedge clk);
        expect0("bp.rel1", 1'b1, 1'b0, 4'h1, 1'b1, 16'd8, 16'd6);
        set0(8'h24, 8'hDB, 8'hBD, 8'h42, 8'h99, 8'h66);
        @(negedge clk);
        expect0("bp.rel2", 1'b1, 1'b1, 4'h0, 1'b1, 16'd9, 16'd6);
        if0.in_valid = 1'b0;
        @(negedge clk);
        expect0("drain", 1'b0, 1'b1, 4'h0, 1'b1, 16'd9, 16'd6);

        // Clear together with a failing transfer, then clear over a pending verdict.
        clear0 = 1'b1;
        if0.in_valid = 1'b1;
        set0(8'h24, 8'hDA, 8'hBD, 8'h42, 8'h99, 8'h66);
        @(negedge clk);
        expect0("clr.xfer", 1'b1, 1'b0, 4'h1, 1'b1, 16'd1, 16'd1);
        if0.in_valid  = 1'b0;
        if0.out_ready = 1'b0;
        @(negedge clk);
        expect0("clr.pend", 1'b1, 1'b0, 4'h1, 1'b0, 16'd0, 16'd0);
        clear0 = 1'b0;
        if0.out_ready = 1'b1;
        @(negedge clk);
        expect0("clr.drain", 1'b0, 1'b0, 4'h1, 1'b0, 16'd0, 16'd0);

        // HALT_ON_ERR=1 instance.
        if1.in_valid = 1'b1;
        set1(8'h24, 8'hDB, 8'hBD, 8'h42, 8'h99, 8'h66);
        @(negedge clk);
        expect1("h.good", 1'b1, 1'b1, 4'h0, 1'b0, 16'd1, 16'd0, 1'b0, 1'b1);
        set1(8'h24, 8'hDA, 8'hBD, 8'h42, 8'h99, 8'h66);
        @(negedge clk);
        expect1("h.err", 1'b1, 1'b0, 4'h1, 1'b1, 16'd2, 16'd1, 1'b1, 1'b0);
        set1(8'h24, 8'hDB, 8'hBD, 8'h42, 8'h99, 8'h66);
        @(negedge clk);
        expect1("h.held1", 1'b0, 1'b0, 4'h1, 1'b1, 16'd2, 16'd1, 1'b1, 1'b0);
        @(negedge clk);
        expect1("h.held2", 1'b0, 1'b0, 4'h1, 1'b1, 16'd2, 16'd1, 1'b1, 1'b0);
        clear1 = 1'b1;
        @(negedge clk);
        clear1 = 1'b0;
        expect1("h.clr", 1'b0, 1'b0, 4'h1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        @(negedge clk);
        expect1("h.resume", 1'b1, 1'b1, 4'h0, 1'b0, 16'd1, 16'd0, 1'b0, 1'b1);
        clear1 = 1'b1;
        set1(8'h24, 8'hDA, 8'hBD, 8'h42, 8'h99, 8'h66);
        @(negedge clk);
        clear1 = 1'b0;
        if1.in_valid = 1'b0;
        expect1("h.clrerr", 1'b1, 1'b0, 4'h1, 1'b1, 16'd1, 16'd1, 1'b1, 1'b0);

        // Reset while a verdict is pending and in_valid is high.
        if0.in_valid  = 1'b1;
        if0.out_ready = 1'b0;
        set0(8'h24, 8'hDB, 8'hBD, 8'h42, 8'h99, 8'h66);
        @(negedge clk);
        expect0("pre.rst", 1'b1, 1'b1, 4'h0, 1'b0, 16'd1, 16'd0);
        #2;
        rst_n = 1'b0;
        #1;
        expect0("async.rst", 1'b0, 1'b0, 4'h0, 1'b0, 16'd0, 16'd0);
        chk("async.rst.halted1", 32'(halted1), 32'h0);
        @(negedge clk);
        expect0("in.rst", 1'b0, 1'b0, 4'h0, 1'b0, 16'd0, 16'd0);
        rst_n = 1'b1;
        if0.out_ready = 1'b1;
        @(negedge clk);
        expect0("post.rst", 1'b1, 1'b1, 4'h0, 1'b0, 16'd1, 16'd0);

        // Counter limits: fill both counters to 0xFFFF, then one more failure.
        clear0 = 1'b1;
        set0(8'h24, 8'hDA, 8'hBD, 8'h42, 8'h99, 8'h66);
        @(negedge clk);
        clear0 = 1'b0;
        expect0("fill.start", 1'b1, 1'b0, 4'h1, 1'b1, 16'd1, 16'd1);
        repeat (65534) @(negedge clk);
        expect0("fill.max", 1'b1, 1'b0, 4'h1, 1'b1, 16'hFFFF, 16'hFFFF);
        @(negedge clk);
        expect0("fill.wrap", 1'b1, 1'b0, 4'h1, 1'b1, 16'h0000, 16'hFFFF);
        @(negedge clk);
        expect0("fill.after", 1'b1, 1'b0, 4'h1, 1'b1, 16'h0001, 16'hFFFF);
        if0.in_valid = 1'b0;
        @(negedge clk);
        expect0("fill.idle", 1'b0, 1'b0, 4'h1, 1'b1, 16'h0001, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_logic_result_checker
